irq_controller: RTL
===================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst_i  input  1  reset, synchronous, active-high.
REQ-003 SHALL: irq_i  input  16  platform interrupt request lines; rising-edge sensitive.
REQ-004 SHALL: mie_i  input  32  machine interrupt-enable CSR value; bit 16+k enables source k.
REQ-005 SHALL: mtvec_i  input  32  trap vector CSR value; [1:0] mode, [31:2] base.
REQ-006 SHALL: mepc_i  input  32  exception PC CSR value; target for mret.
REQ-007 SHALL: trap_ready_i  input  1  core is at an instruction boundary and can accept a trap.
REQ-008 SHALL: mret_i  input  1  core executed mret this cycle.
REQ-009 SHALL: trap_o  output  1  one-cycle pulse; drives the CSR trap input (mepc/mcause capture).
REQ-010 SHALL: mcause_o  output  32  cause value accompanying trap_o.
REQ-011 SHALL: pc_redirect_o  output  1  fetch-redirect strobe.
REQ-012 SHALL: pc_target_o  output  32  redirect target PC.
REQ-013 SHALL: irq_pending_o  output  16  pending register, usable for CSR mip read-back.

Function
REQ-014 SHALL: register irq_i each cycle; when irq_i[k]=1 and previous sample=0, set pending[k], regardless of mie_i.
REQ-015 SHALL: eligible = pending & mie_i[31:16]; select the lowest-index eligible source (index 0 is highest priority).
REQ-016 SHALL: implement the states IDLE, TRAP, SERVICE and RETURN.
REQ-017 SHALL: in IDLE, go to TRAP when eligible!=0 and trap_ready_i=1; otherwise stay in IDLE, holding pending bits.
REQ-018 SHALL: in IDLE, go to RETURN on mret_i=1 (exception return); mret_i takes precedence over a new trap.
REQ-019 SHALL: in TRAP (exactly one cycle), assert trap_o=1 and pc_redirect_o=1, set mcause_o = {1'b1, 26'b0, 5'(16+k)}, clear pending[k], then go to SERVICE.
REQ-020 SHALL: select the source k at the IDLE->TRAP transition and hold it stable through TRAP.
REQ-021 SHALL: in TRAP with mtvec_i[1:0]=00 (direct), set pc_target_o = {mtvec_i[31:2],2'b00}.
REQ-022 SHALL: in TRAP with mtvec_i[1:0]=01 (vectored), set pc_target_o = base + 4*(16+k), using 32-bit wrap-around arithmetic.
REQ-023 SHALL: treat mtvec_i modes 10 and 11 as direct.
REQ-024 SHALL: in SERVICE, take no new trap (no nesting), keep latching edges into pending, and go to RETURN on mret_i=1.
REQ-025 SHALL: in RETURN (one cycle), assert pc_redirect_o=1 with pc_target_o = mepc_i, then go to IDLE.
REQ-026 SHALL: ignore mret_i while in TRAP or RETURN.
REQ-027 SHALL: when a set and a clear of pending[k] occur in the same cycle, let the set win.
REQ-028 SHALL: drive trap_o=0, pc_redirect_o=0 and mcause_o=0 in IDLE, SERVICE and RETURN (mcause_o is meaningful only while trap_o=1); drive pc_target_o=0 whenever pc_redirect_o=0.
REQ-029 SHALL: give a latency from irq edge to trap_o of 2 cycles minimum (edge sample + IDLE decision), extended by cycles where trap_ready_i=0.

Reset
REQ-030 SHALL: on rst_i=1, set state to IDLE, pending to 0, the irq_i sample register to 0, and all outputs to 0, taking effect at the next clock edge.
REQ-031 SHALL: on reset in any state (including mid-TRAP or mid-SERVICE), abandon the in-service source without a return redirect.
REQ-032 SHALL: after reset, treat an irq_i line already high as an edge on the first sampled cycle.

Structure
REQ-033 SHALL: place the irq_state_t enum, IRQ_NUM=16, IRQ_CAUSE_BASE=16, MTVEC_DIRECT=2'b00 and MTVEC_VECTORED=2'b01 in csr_pkg.
REQ-034 SHALL: implement the lowest-index selection as the sub-module irq_prio_enc (16-bit input -> valid + 4-bit index).

Verification
REQ-035 SHALL cover: mie_i=0x0001_0000, mtvec_i=0x0000_1000, trap_ready_i=1, rising edge on irq_i[0] -> trap_o pulse 2 cycles later, mcause_o=0x8000_0010, pc_target_o=0x0000_1000.
REQ-036 SHALL cover: mtvec_i=0x0000_2001, edges on irq_i[3] and irq_i[5] in the same cycle, all enabled -> first trap mcause_o=0x8000_0013, pc_target_o=0x0000_204C; after mret, second trap mcause_o=0x8000_0015, pc_target_o=0x0000_2054.
REQ-037 SHALL cover: edge on irq_i[2] with mie_i=0 -> no trap and irq_pending_o=0x0004; then set mie_i[18] -> trap taken with mcause_o=0x8000_0012.
REQ-038 SHALL cover: in SERVICE, edge on irq_i[1] -> no trap; mret_i with mepc_i=0x0000_0400 -> pc_redirect_o=1 and pc_target_o=0x400 for one cycle, then the irq_i[1] trap follows.
REQ-039 SHALL cover: trap_ready_i held 0 for 5 cycles with an eligible source pending -> trap_o stays 0; trap_o asserts 1 cycle after trap_ready_i rises.
REQ-040 SHALL cover: rst_i asserted in SERVICE with pending=0x0010 -> next cycle in IDLE, irq_pending_o=0, and no redirect issued.

Source files
------------

// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared types, constants and helpers for the machine-mode interrupt path.
//   irq_state_t     : controller FSM states
//   IRQ_NUM         : number of platform interrupt lines
//   IRQ_CAUSE_BASE  : mcause code of platform interrupt 0
//   MTVEC_DIRECT    : mtvec mode, all traps go to base
//   MTVEC_VECTORED  : mtvec mode, trap goes to base + 4*cause
// -----------------------------------------------------------------------------
package csr_pkg;

  localparam int         IRQ_NUM        = 16;
  localparam int         IRQ_CAUSE_BASE = 16;
  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    TRAP,
    SERVICE,
    RETURN
  } irq_state_t;

  // Exception code of platform source idx (16..31 always fits in 5 bits).
  function automatic logic [4:0] irq_code(input logic [3:0] idx);
    return 5'(IRQ_CAUSE_BASE) + {1'b0, idx};
  endfunction

  // mcause for an interrupt: interrupt flag in bit 31, code in the low bits.
  function automatic logic [31:0] irq_mcause(input logic [3:0] idx);
    return {1'b1, 26'b0, irq_code(idx)};
  endfunction

  // Trap target. Only mode 01 is vectored; 00, 10 and 11 all behave as direct.
  // The add wraps naturally in 32 bits.
  function automatic logic [31:0] irq_vector(input logic [31:0] mtvec,
                                             input logic [3:0]  idx);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == MTVEC_VECTORED) begin
      return base + {25'b0, irq_code(idx), 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Fixed-priority encoder: reports the lowest set bit of req (bit 0 wins).
//   req   : in  IRQ_NUM  request vector
//   valid : out 1        any request bit set
//   idx   : out 4        index of the lowest set bit (0 when valid=0)
// -----------------------------------------------------------------------------
module irq_prio_enc
  import csr_pkg::*;
(
  input  logic [IRQ_NUM-1:0] req,
  output logic               valid,
  output logic [3:0]         idx
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise a latch would be inferred.
    valid = |req;
    idx   = '0;
    // Scan from the top down so the last hit, the lowest index, wins.
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Edge-triggered machine-mode interrupt controller. Latches rising edges of
// the platform lines into a pending register, picks the highest-priority
// enabled source, raises a one-cycle trap with cause and vector target, and
// redirects fetch to mepc on mret. No nesting while a handler runs.
//   clk_i         : in  1   clock, rising edge
//   rst_i         : in  1   synchronous active-high reset
//   irq_i         : in  16  platform interrupt lines (rising-edge sensitive)
//   mie_i         : in  32  mie CSR; bit 16+k enables source k
//   mtvec_i       : in  32  mtvec CSR; [1:0] mode, [31:2] base
//   mepc_i        : in  32  mepc CSR; mret target
//   trap_ready_i  : in  1   core can take a trap this cycle
//   mret_i        : in  1   core executed mret this cycle
//   trap_o        : out 1   one-cycle trap pulse
//   mcause_o      : out 32  cause accompanying trap_o, else 0
//   pc_redirect_o : out 1   fetch redirect strobe
//   pc_target_o   : out 32  redirect target, else 0
//   irq_pending_o : out 16  pending register (mip read-back)
// -----------------------------------------------------------------------------
module irq_controller
  import csr_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM-1:0] irq_i,
  input  logic [31:0]        mie_i,
  input  logic [31:0]        mtvec_i,
  input  logic [31:0]        mepc_i,
  input  logic               trap_ready_i,
  input  logic               mret_i,
  output logic               trap_o,
  output logic [31:0]        mcause_o,
  output logic               pc_redirect_o,
  output logic [31:0]        pc_target_o,
  output logic [IRQ_NUM-1:0] irq_pending_o
);

  irq_state_t         state;
  logic [IRQ_NUM-1:0] irq_q;
  logic [IRQ_NUM-1:0] pending;
  logic [IRQ_NUM-1:0] pending_next;
  logic [IRQ_NUM-1:0] rise;
  logic [IRQ_NUM-1:0] clr_mask;
  logic [IRQ_NUM-1:0] eligible;
  logic [3:0]         sel_idx;
  logic [3:0]         enc_idx;
  logic               enc_valid;
  logic               unused_mie;

  // Only the platform-interrupt enables are relevant here.
  assign unused_mie    = ^mie_i[15:0];

  assign irq_pending_o = pending;
  assign rise          = irq_i & ~irq_q;
  assign eligible      = pending & mie_i[31:16];

  irq_prio_enc u_prio_enc (
    .req   (eligible),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // The serviced source is cleared as TRAP ends; a fresh edge on the same
  // line in that cycle re-sets it because the OR comes last.
  always_comb begin
    clr_mask = '0;
    if (state == TRAP) clr_mask[sel_idx] = 1'b1;
    pending_next = (pending & ~clr_mask) | rise;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      irq_q         <= '0;
      pending       <= '0;
      sel_idx       <= '0;
      trap_o        <= 1'b0;
      mcause_o      <= '0;
      pc_redirect_o <= 1'b0;
      pc_target_o   <= '0;
    end else begin
      irq_q         <= irq_i;
      pending       <= pending_next;
      // Outputs are pulses: default low, raised only on entry to TRAP/RETURN.
      trap_o        <= 1'b0;
      mcause_o      <= '0;
      pc_redirect_o <= 1'b0;
      pc_target_o   <= '0;
      case (state)
        IDLE: begin
          // mret outranks a new trap.
          if (mret_i) begin
            state         <= RETURN;
            pc_redirect_o <= 1'b1;
            pc_target_o   <= mepc_i;
          end else if (trap_ready_i && enc_valid) begin
            state         <= TRAP;
            sel_idx       <= enc_idx;
            trap_o        <= 1'b1;
            mcause_o      <= irq_mcause(enc_idx);
            pc_redirect_o <= 1'b1;
            pc_target_o   <= irq_vector(mtvec_i, enc_idx);
          end
        end
        TRAP:    state <= SERVICE;
        SERVICE: begin
          if (mret_i) begin
            state         <= RETURN;
            pc_redirect_o <= 1'b1;
            pc_target_o   <= mepc_i;
          end
        end
        RETURN:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
